apb_slave_regfile: RTL and testbench

Parametrised APB completer fronting a register bank of `DEPTH` words of `DATA_WIDTH` bits. It extends the plain APB signal bundle with byte-lane write strobes, a programmable number of wait states, and error reporting on `pslverr` for out-of-range, misaligned and protocol-violating accesses. It sits behind the APB interface as the standard configurable peripheral target for environment and DUT-side register blocks.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slave_regfile_if.sv | 27 ++
 rtl/apb_regbank.sv | 35 +++
 rtl/apb_slave_regfile.sv | 151 +++++++++++++++
 tb/tb_apb_slave_regfile.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR
  } apb_state_e;

  typedef enum logic [1:0] {
    NONE,
    RANGE,
    ALIGN,
    PROTO
  } apb_err_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle with byte strobes; the requester drives the master modport.
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_regbank.sv
// DEPTH x DATA_WIDTH register storage with byte-lane write and combinational read.
module apb_regbank #(
  parameter int  DEPTH      = 16,
  parameter int  DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BYTES-1:0]      wstrb_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the bank is flops, not a RAM macro, so it can and must honour reset;
  // a RAM-style array would drop the reset branch.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: decode, wait-state FSM and registered response in front of apb_regbank.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input logic                pclk,
  input logic                preset,
  apb_slave_regfile_if.slave apb
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT  = WAIT_CNT_W'(WAIT_STATES);

  apb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      strb_q;
  apb_err_e              err_q;

  logic [ADDR_WIDTH-1:0] offset, index;
  apb_err_e              live_err;
  logic                  cap_en, we, resp_fire;
  apb_err_e              resp_cause;
  logic                  rsp_write;
  logic [IDX_W-1:0]      rsp_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  assign offset = apb.paddr - BASE_ADDR;
  assign index  = offset >> LSB;

  always_comb begin
    live_err = NONE;
    if (apb.paddr < BASE_ADDR || index >= DEPTH_A) live_err = RANGE;
    else if ((offset & ALIGN_MASK) != '0)         live_err = ALIGN;
  end

  // The setup phase is recognised while still in IDLE, so the response can
  // already be registered for the first access cycle; SETUP is never occupied.
  always_comb begin
    rsp_write = (state_q == IDLE) ? apb.pwrite : write_q;
    rsp_idx   = (state_q == IDLE) ? index[IDX_W-1:0] : idx_q;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_en     = 1'b0;
    we         = 1'b0;
    resp_fire  = 1'b0;
    resp_cause = err_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          cap_en     = 1'b1;
          cnt_d      = WAIT_INIT;
          state_d    = ACCESS;
          resp_fire  = (WAIT_INIT == '0);
          resp_cause = live_err;
        end else if (apb.psel && apb.penable) begin
          state_d    = ERR;
          resp_fire  = 1'b1;
          resp_cause = PROTO;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          we      = write_q && (err_q == NONE);
          state_d = IDLE;
        end else if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q - WAIT_CNT_W'(1);
          resp_fire = (cnt_q == WAIT_CNT_W'(1));
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (resp_fire) begin
      pready_d  = 1'b1;
      pslverr_d = (resp_cause != NONE);
      if (!rsp_write && resp_cause == NONE) prdata_d = rd_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (cap_en) begin
        write_q <= apb.pwrite;
        idx_q   <= index[IDX_W-1:0];
        wdata_q <= apb.pwdata;
        strb_q  <= apb.pstrb;
        err_q   <= live_err;
      end
    end
  end

  apb_regbank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regbank (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (we),
    .widx_i  (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .ridx_i  (rsp_idx),
    .rdata_o (rd_data)
  );

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three completers (0, 3 and 2 wait states) share one driven bus; one is observed at a time.
module tb_apb_slave_regfile;

  typedef struct {
    string       tag;
    logic        wr;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  logic [2:0]  pready_v, pslverr_v;
  logic [31:0] prdata_v [3];
  int          dsel;
  logic        pready, pslverr;
  logic [31:0] prdata;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.psel    = psel;
    assign bus.penable = penable;
    assign bus.pwrite  = pwrite;
    assign bus.paddr   = paddr;
    assign bus.pwdata  = pwdata;
    assign bus.pstrb   = pstrb;
    apb_slave_regfile #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH       (16),
      .BASE_ADDR   (32'h0),
      .WAIT_STATES (WS)
    ) u_dut (
      .pclk   (pclk),
      .preset (preset),
      .apb    (bus)
    );
    assign pready_v[g]  = bus.pready;
    assign pslverr_v[g] = bus.pslverr;
    assign prdata_v[g]  = bus.prdata;
  end

  always_comb begin
    pready  = pready_v[dsel];
    pslverr = pslverr_v[dsel];
    prdata  = prdata_v[dsel];
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    preset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    tick();
    tick();
    preset  = 1'b0;
  endtask

  // One complete transfer; leaves the bus idle one cycle after pready so a
  // following call forms a back-to-back transfer.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_cycles);
    exp_t e;
    int   n;
    logic idle_bad;
    e.tag = tag; e.wr = wr; e.rdata = exp_rdata; e.err = exp_err; e.cycles = exp_cycles;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    tick();
    penable  = 1'b1;
    n        = 1;
    idle_bad = 1'b0;
    while (!pready && n < 40) begin
      if (prdata !== 32'h0) idle_bad = 1'b1;
      tick();
      n++;
    end
    check({tag, ":pready"}, 64'(pready), 64'(1));
    e = sb.pop_front();
    if (!e.wr) check({e.tag, ":prdata"}, 64'(prdata), 64'(e.rdata));
    check({e.tag, ":pslverr"}, 64'(pslverr), 64'(e.err));
    check({e.tag, ":cycles"}, 64'(n + 1), 64'(e.cycles));
    check({e.tag, ":prdata_while_waiting"}, 64'(idle_bad), 64'(0));
    tick();
    psel = 1'b0; penable = 1'b0;
    check({e.tag, ":pready_pulse"}, 64'(pready), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    dsel = 0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    do_reset();
    for (int d = 0; d < 3; d++) begin
      dsel = d;
      check($sformatf("reset%0d:pready", d),  64'(pready),  64'(0));
      check($sformatf("reset%0d:pslverr", d), 64'(pslverr), 64'(0));
      check($sformatf("reset%0d:prdata", d),  64'(prdata),  64'(0));
    end

    // Zero wait states
    dsel = 0;
    xfer("wr8",        1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2);
    xfer("rd8",        1'b0, 32'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2);
    xfer("wrC",        1'b1, 32'h0C, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 2);
    xfer("wrC_strb",   1'b1, 32'h0C, 32'h11223344, 4'h5, 32'h0,        1'b0, 2);
    xfer("rdC",        1'b0, 32'h0C, 32'h0,        4'h0, 32'hAA22CC44, 1'b0, 2);
    xfer("wr8_nostrb", 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 2);
    xfer("rd8_nostrb", 1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2);
    xfer("wr_last",    1'b1, 32'h3C, 32'hA5A55A5A, 4'hF, 32'h0,        1'b0, 2);
    xfer("rd_last",    1'b0, 32'h3C, 32'h0,        4'h0, 32'hA5A55A5A, 1'b0, 2);
    xfer("wr_range",   1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1, 2);
    xfer("rd0",        1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0, 2);
    xfer("rd_misal",   1'b0, 32'h02, 32'h0,        4'h0, 32'h0,        1'b1, 2);
    xfer("wr_misal",   1'b1, 32'h09, 32'h0,        4'hF, 32'h0,        1'b1, 2);
    xfer("rd8_misal",  1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2);

    // Access phase with no setup
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    tick();
    psel = 1'b0; penable = 1'b0;
    check("proto:pready",  64'(pready),  64'(1));
    check("proto:pslverr", 64'(pslverr), 64'(1));
    check("proto:prdata",  64'(prdata),  64'(0));
    tick();
    check("proto:pready_pulse", 64'(pready), 64'(0));

    // Three wait states, back-to-back, then an aborted write
    dsel = 1;
    do_reset();
    xfer("ws3_wr", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 5);
    xfer("ws3_rd", 1'b0, 32'h20, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 5);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h55; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pready) saw = 1'b1;
      tick();
    end
    check("abort:no_pready", 64'(saw), 64'(0));
    xfer("abort_rd", 1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0, 5);

    // Two wait states, reset during the access phase of a write
    dsel = 2;
    do_reset();
    xfer("ws2_wr4", 1'b1, 32'h04, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0, 4);
    xfer("ws2_rd4", 1'b0, 32'h04, 32'h0,        4'h0, 32'h0BADCAFE, 1'b0, 4);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h12345678; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    preset = 1'b1;
    tick();
    check("rst_mid:pready",  64'(pready),  64'(0));
    check("rst_mid:pslverr", 64'(pslverr), 64'(0));
    check("rst_mid:prdata",  64'(prdata),  64'(0));
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer("rst_rd4",   1'b0, 32'h04, 32'h0,  4'h0, 32'h0,  1'b0, 4);
    xfer("post_wr4",  1'b1, 32'h04, 32'h77, 4'hF, 32'h0,  1'b0, 4);
    xfer("post_rd4",  1'b0, 32'h04, 32'h0,  4'h0, 32'h77, 1'b0, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
